// File: rtl/axi_mm_slave_rxfifo.sv
// Per-channel receive FIFO for the AXI-MM slave side of the link: buffers packed channel
// words, presents them first-word fall-through, and returns one credit per consumed entry.
module axi_mm_slave_rxfifo #(
  parameter int unsigned WIDTH = 49,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_wr,
  input  logic                       rst_wr,
  input  logic                       rx_online,
  input  logic                       rxfifo_i_push,
  input  logic [WIDTH-1:0]           rxfifo_i_data,
  output logic                       user_vld,
  output logic [WIDTH-1:0]           rxfifo_data,
  input  logic                       user_ready,
  output logic                       tx_credit,
  output logic [$clog2(DEPTH+1)-1:0] rxfifo_count,
  output logic                       rx_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q, wp_d;
  logic [AW:0]      rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             credit_q, credit_d;
  logic             ovf_q, ovf_d;

  logic full, empty, pop, push_ok, ovf_evt;

  assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty   = (wp_q == rp_q);
  assign pop     = !empty && user_ready;
  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign push_ok = rxfifo_i_push && rx_online && (!full || pop);
  assign ovf_evt = rxfifo_i_push && rx_online && full && !pop;

  assign user_vld     = !empty;
  assign rxfifo_data  = mem_q[rp_q[AW-1:0]];
  assign tx_credit    = credit_q;
  assign rxfifo_count = count_q;
  assign rx_overflow  = ovf_q;

  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    ovf_d    = ovf_q | ovf_evt;
    credit_d = pop && rx_online;
    if (!rx_online) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push_ok) wp_d = wp_q + 1'b1;
      if (pop)     rp_d = rp_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk_wr) begin
    if (push_ok) mem_q[wp_q[AW-1:0]] <= rxfifo_i_data;
  end

endmodule
